// File: rtl/operand_accumulator_pkg.sv
// Shared definitions for the operand accumulator, its adder and later ALU stages.
package operand_accumulator_pkg;

  // Default datapath width shared with the two-operand adder.
  localparam int unsigned WIDTH_DEFAULT   = 32;
  // Default longest burst the accumulator accepts.
  localparam int unsigned MAX_LEN_DEFAULT = 16;

  // Accumulator FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bits needed to hold a burst length or count of 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/TwoOpAdder.sv
// Combinational two-operand adder; the carry-out is recovered by the caller.
module TwoOpAdder
  import operand_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] out
);

  // Sum modulo 2^WIDTH.
  assign out = op1 + op2;

endmodule

// File: rtl/operand_accumulator.sv
// Sums a burst of 1..MAX_LEN unsigned operands from a valid/ready stream and
// presents the total, operand count and sticky carry on a valid/ready result port.
module operand_accumulator
  import operand_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEFAULT,
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT,
  parameter int unsigned LEN_W   = len_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             sum_ovf,
  output logic [LEN_W-1:0] sum_cnt,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_d;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_d;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_d;
  logic             r_ovf;
  logic             w_ovf_d;
  logic             r_in_ready;
  logic             r_sum_valid;

  logic [WIDTH-1:0] w_add_out;
  logic [LEN_W-1:0] w_len_eff;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_taken;

  // acc + incoming word; only meaningful while accumulating.
  TwoOpAdder #(
    .WIDTH (WIDTH)
  ) u_add (
    .op1 (r_acc),
    .op2 (in_data),
    .out (w_add_out)
  );

  assign w_accept  = in_valid && r_in_ready;
  assign w_taken   = r_sum_valid && sum_ready;
  assign w_cnt_inc = r_cnt + LenOne;

  // Burst length as the first word sees it: 0 means 1, oversize saturates at MAX_LEN.
  always_comb begin
    w_len_eff = in_len;
    if (in_len == '0) begin
      w_len_eff = LenOne;
    end else if (in_len > LenMax) begin
      w_len_eff = LenMax;
    end
  end

  // Next-state logic for the FSM, accumulator, counter and carry flag.
  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_len_d   = r_len;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // First word loads directly; no add.
          w_acc_d = in_data;
          w_cnt_d = LenOne;
          w_ovf_d = 1'b0;
          w_len_d = w_len_eff;
          if ((w_len_eff == LenOne) || in_last) begin
            w_state_d = ST_DONE;
          end else begin
            w_state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_acc_d = w_add_out;
          w_cnt_d = w_cnt_inc;
          // A wrapped sum is smaller than either addend: that is the carry-out.
          w_ovf_d = r_ovf | (w_add_out < r_acc);
          if ((w_cnt_inc == r_len) || in_last) begin
            w_state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (w_taken) begin
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_sum_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_len       <= w_len_d;
      r_ovf       <= w_ovf_d;
      r_in_ready  <= (w_state_d != ST_DONE);
      r_sum_valid <= (w_state_d == ST_DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign sum_valid = r_sum_valid;
  assign sum       = r_acc;
  assign sum_cnt   = r_cnt;
  assign sum_ovf   = r_ovf;

  // The two handshake flags are always complementary.
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    r_in_ready == !r_sum_valid);

  // The counter never runs past the sampled burst length.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= r_len);

endmodule

// File: tb/tb_operand_accumulator.sv
// Scoreboard bench for operand_accumulator: drivers push expected results,
// a monitor pops and compares on every result handshake.
module tb_operand_accumulator;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic [LEN_W-1:0] sum_cnt;
  logic             sum_valid;
  logic             sum_ready;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [LEN_W-1:0] cnt;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   sink_random = 1'b0;

  operand_accumulator #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sum_ovf   (sum_ovf),
    .sum_cnt   (sum_cnt),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every result handshake must match the oldest expected result.
  always @(negedge clk) begin
    res_t e;
    if (!rst && sum_valid && sum_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%h ovf=%0d cnt=%0d, required no result",
                 sum, sum_ovf, sum_cnt);
      end else begin
        e = exp_q.pop_front();
        if (sum !== e.sum || sum_ovf !== e.ovf || sum_cnt !== e.cnt) begin
          errors++;
          $display("FAIL result: got sum=%h ovf=%0d cnt=%0d, required sum=%h ovf=%0d cnt=%0d",
                   sum, sum_ovf, sum_cnt, e.sum, e.ovf, e.cnt);
        end
      end
    end
  end

  // Random result-side back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sink_random) sum_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] s, input logic o, input logic [LEN_W-1:0] c);
    res_t e;
    e.sum = s;
    e.ovf = o;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Offer one word and return just after the edge that accepts it.
  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] len, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len;
    in_last  = last;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    step();
    // Garbage on the qualified inputs while idle; the DUT must ignore it.
    in_valid = 1'b0;
    in_data  = $urandom;
    in_len   = LEN_W'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || sum_valid) && n < 500) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || sum_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d sum_valid=%0d, required 0 and 0",
               exp_q.size(), sum_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_last   = 1'b0;
    sum_ready = 1'b0;
    repeat (3) step();
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_sum_cnt", 32'(sum_cnt), 32'd0);
    chk("rst_sum_ovf", 32'(sum_ovf), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: four back-to-back words, result one cycle after the last.
    sum_ready = 1'b1;
    push(32'd10, 1'b0, 5'd4);
    send(32'd1, 5'd4, 1'b0);
    send(32'd2, 5'd4, 1'b0);
    send(32'd3, 5'd4, 1'b0);
    chk("t1_valid_before_last", 32'(sum_valid), 32'd0);
    send(32'd4, 5'd4, 1'b0);
    chk("t1_valid_after_last", 32'(sum_valid), 32'd1);
    drain();

    // 2: carry-out wraps and latches.
    push(32'h0000_0001, 1'b1, 5'd2);
    send(32'hFFFF_FFFF, 5'd2, 1'b0);
    send(32'h0000_0002, 5'd2, 1'b0);
    drain();
    push(32'h0000_0000, 1'b1, 5'd2);
    send(32'hFFFF_FFFF, 5'd2, 1'b0);
    send(32'h0000_0001, 5'd2, 1'b0);
    drain();

    // 3: early termination, then a zero-length burst treated as one word.
    push(32'd18, 1'b0, 5'd3);
    send(32'd5, 5'd8, 1'b0);
    send(32'd6, 5'd8, 1'b0);
    send(32'd7, 5'd8, 1'b1);
    push(32'd9, 1'b0, 5'd1);
    send(32'd9, 5'd0, 1'b0);
    drain();

    // in_last on the first word wins over in_len; oversize in_len clamps to MAX_LEN.
    push(32'd42, 1'b0, 5'd1);
    send(32'd42, 5'd10, 1'b1);
    push(32'd16, 1'b0, 5'd16);
    for (int i = 0; i < 16; i++) send(32'd1, (i == 0) ? 5'd31 : 5'd3, 1'b0);
    drain();

    // 4: result stalled while the next word waits.
    sum_ready = 1'b0;
    push(32'd7, 1'b0, 5'd1);
    send(32'd7, 5'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h11;
    in_len   = 5'd1;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready_stall", 32'(in_ready), 32'd0);
      chk("t4_sum_stable", sum, 32'd7);
      chk("t4_cnt_stable", 32'(sum_cnt), 32'd1);
      chk("t4_ovf_stable", 32'(sum_ovf), 32'd0);
      step();
    end
    push(32'h11, 1'b0, 5'd1);
    sum_ready = 1'b1;
    send(32'h11, 5'd1, 1'b0);
    drain();

    // 5: reset mid-burst discards it; the monitor flags any stray result.
    send(32'd3, 5'd4, 1'b0);
    send(32'd4, 5'd4, 1'b0);
    rst = 1'b1;
    step();
    chk("t5_rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("t5_rst_sum", sum, 32'd0);
    chk("t5_rst_cnt", 32'(sum_cnt), 32'd0);
    chk("t5_rst_ovf", 32'(sum_ovf), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_sum_valid_idle", 32'(sum_valid), 32'd0);
    push(32'd2, 1'b0, 5'd2);
    send(32'd1, 5'd2, 1'b0);
    send(32'd1, 5'd2, 1'b0);
    drain();

    // 6: random bursts with bubbles on both sides against a reference sum.
    sink_random = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      int unsigned      len;
      bit               use_last;
      logic [LEN_W-1:0] lenf;
      logic [WIDTH:0]   acc;
      logic             ovf;
      logic [WIDTH-1:0] w;
      len      = $urandom_range(1, MAX_LEN);
      use_last = 1'($urandom_range(0, 1));
      if (use_last) lenf = LEN_W'($urandom_range(len, 31));
      else if (len == 1 && $urandom_range(0, 1) == 1) lenf = '0;
      else lenf = LEN_W'(len);
      acc = '0;
      ovf = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
        w = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                        : 32'($urandom);
        acc = {1'b0, acc[WIDTH-1:0]} + {1'b0, w};
        ovf = ovf | acc[WIDTH];
        if (i == 0) push_later(w, lenf, use_last && len == 1, acc[WIDTH-1:0], ovf, len);
        else if (i == int'(len) - 1) begin
          exp_q[exp_q.size() - 1].sum = acc[WIDTH-1:0];
          exp_q[exp_q.size() - 1].ovf = ovf;
          if ($urandom_range(0, 3) == 0) step();
          send(w, LEN_W'($urandom), use_last);
        end else begin
          if ($urandom_range(0, 3) == 0) step();
          send(w, LEN_W'($urandom), 1'b0);
        end
      end
    end
    sink_random = 1'b0;
    sum_ready   = 1'b1;
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // First word of a random burst: record the expected result, then send the word.
  task automatic push_later(input logic [WIDTH-1:0] w, input logic [LEN_W-1:0] lenf,
                            input bit last, input logic [WIDTH-1:0] s, input logic o,
                            input int unsigned len);
    push(s, o, LEN_W'(len));
    if ($urandom_range(0, 3) == 0) step();
    send(w, lenf, last);
  endtask

endmodule
